prog_loader_mc: RTL

Parametrised program/data loader that replaces the fixed, tied-off program-load path in the core harness. Accepts load commands plus a valid/ready word stream. Packs instruction words into LANES-wide imem lines and writes data words to dmem. Holds the pipeline in reset until a command flagged `last` has fully completed.

---
 rtl/prog_loader_mc_pkg.sv | 23 ++
 rtl/prog_loader_mc_line_packer.sv | 78 +++++++
 rtl/prog_loader_mc.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/prog_loader_mc_pkg.sv
// ============================================================================
// Module  : prog_loader_mc_pkg
// Brief   : Shared constants for the program/data loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_loader_mc_pkg;

    localparam logic [31:0] c_nop_word = 32'h0000_0013;

    localparam logic c_tgt_imem = 1'b0;
    localparam logic c_tgt_dmem = 1'b1;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load_i = 3'd1;
    localparam logic [2:0] c_st_load_d = 3'd2;
    localparam logic [2:0] c_st_pad    = 3'd3;
    localparam logic [2:0] c_st_fin    = 3'd4;

endpackage

`default_nettype wire

// File: rtl/prog_loader_mc_line_packer.sv
// ============================================================================
// Module  : line_packer
// Brief   : Collects instruction words into one imem line; pads with NOPs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module line_packer
    import prog_loader_mc_pkg::*;
#(
    parameter int                   INSN_LEN = 32,
    parameter int                   LANES    = 4,
    parameter logic [INSN_LEN-1:0]  NOP_WORD = INSN_LEN'(c_nop_word)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_word_valid,
    input  logic [INSN_LEN-1:0]       i_word,
    input  logic                      i_pad,
    output logic                      o_line_full,
    output logic [LANES*INSN_LEN-1:0] o_line_data
);

    localparam int c_lane_w = (LANES > 1) ? $clog2(LANES) : 1;

    logic [INSN_LEN-1:0] r_lanes [LANES];
    logic [c_lane_w-1:0] r_lane_cnt;
    logic                w_last_lane;

    generate
        if (LANES > 1) begin : g_multi_lane
            assign w_last_lane = (r_lane_cnt == c_lane_w'(LANES - 1));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_lane_cnt <= '0;
                end else if (o_line_full) begin
                    r_lane_cnt <= '0;
                end else if (i_word_valid) begin
                    r_lane_cnt <= r_lane_cnt + c_lane_w'(1);
                end
            end
        end else begin : g_single_lane
            assign w_last_lane = 1'b1;
            assign r_lane_cnt  = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                r_lanes[i] <= '0;
            end
        end else if (i_word_valid) begin
            r_lanes[r_lane_cnt] <= i_word;
        end
    end

    // The completing word bypasses the lane register so the line can be
    // written on the cycle right after its last word is accepted.
    always_comb begin
        o_line_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i_word_valid && (r_lane_cnt == c_lane_w'(i))) begin
                o_line_data[(LANES-1-i)*INSN_LEN +: INSN_LEN] = i_word;
            end else if (i_pad && (c_lane_w'(i) >= r_lane_cnt)) begin
                o_line_data[(LANES-1-i)*INSN_LEN +: INSN_LEN] = NOP_WORD;
            end else begin
                o_line_data[(LANES-1-i)*INSN_LEN +: INSN_LEN] = r_lanes[i];
            end
        end
    end

    assign o_line_full = (i_word_valid && w_last_lane) || i_pad;

endmodule

`default_nettype wire

// File: rtl/prog_loader_mc.sv
// ============================================================================
// Module  : prog_loader_mc
// Brief   : Command-driven imem/dmem loader holding the core until release.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader_mc
    import prog_loader_mc_pkg::*;
#(
    parameter int                   INSN_LEN = 32,
    parameter int                   LANES    = 4,
    parameter int                   IMEM_AW  = 9,
    parameter int                   ADDR_LEN = 32,
    parameter int                   CNT_W    = 16,
    parameter logic [INSN_LEN-1:0]  NOP_WORD = INSN_LEN'(c_nop_word)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_target,
    input  logic [ADDR_LEN-1:0]       cmd_base,
    input  logic [CNT_W-1:0]          cmd_count,
    input  logic                      cmd_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INSN_LEN-1:0]       in_data,
    output logic                      imem_we,
    output logic [IMEM_AW-1:0]        imem_addr,
    output logic [LANES*INSN_LEN-1:0] imem_wdata,
    output logic                      dmem_we,
    output logic [ADDR_LEN-1:0]       dmem_addr,
    output logic [INSN_LEN-1:0]       dmem_wdata,
    output logic                      core_hold,
    output logic                      busy,
    output logic                      done
);

    logic [2:0]                r_state;
    logic [ADDR_LEN-1:0]       r_base;
    logic [CNT_W-1:0]          r_count;
    logic [CNT_W-1:0]          r_word_idx;
    logic [IMEM_AW-1:0]        r_line_idx;
    logic                      r_last;

    logic                      w_cmd_acc;
    logic                      w_in_acc;
    logic                      w_final;
    logic                      w_word_i;
    logic                      w_pad;
    logic                      w_line_full;
    logic [LANES*INSN_LEN-1:0] w_line_data;

    // The done cycle still blocks new commands so a waiting producer sees
    // completion before its next command is taken.
    assign cmd_ready = (r_state == c_st_idle) && !done;
    assign in_ready  = (r_state == c_st_load_i) || (r_state == c_st_load_d);
    assign busy      = (r_state != c_st_idle);
    assign w_cmd_acc = cmd_valid && cmd_ready;
    assign w_in_acc  = in_valid && in_ready;
    assign w_final   = w_in_acc && (r_word_idx == (r_count - CNT_W'(1)));
    assign w_word_i  = w_in_acc && (r_state == c_st_load_i);
    assign w_pad     = (r_state == c_st_pad);

    line_packer #(
        .INSN_LEN (INSN_LEN),
        .LANES    (LANES),
        .NOP_WORD (NOP_WORD)
    ) u_line_packer (
        .clk          (clk),
        .reset        (reset),
        .i_word_valid (w_word_i),
        .i_word       (in_data),
        .i_pad        (w_pad),
        .o_line_full  (w_line_full),
        .o_line_data  (w_line_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_base     <= '0;
            r_count    <= '0;
            r_word_idx <= '0;
            r_line_idx <= '0;
            r_last     <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            done    <= 1'b0;

            if (w_line_full) begin
                imem_we    <= 1'b1;
                imem_addr  <= r_base[IMEM_AW+3:4] + r_line_idx;
                imem_wdata <= w_line_data;
                r_line_idx <= r_line_idx + IMEM_AW'(1);
            end

            case (r_state)
                c_st_idle: begin
                    if (w_cmd_acc) begin
                        r_base     <= cmd_base;
                        r_count    <= cmd_count;
                        r_last     <= cmd_last;
                        r_word_idx <= '0;
                        r_line_idx <= '0;
                        if (cmd_count == '0) begin
                            r_state <= c_st_fin;
                        end else if (cmd_target == c_tgt_dmem) begin
                            r_state <= c_st_load_d;
                        end else begin
                            r_state <= c_st_load_i;
                        end
                    end
                end
                c_st_load_i: begin
                    if (w_in_acc) begin
                        r_word_idx <= r_word_idx + CNT_W'(1);
                        if (w_final) begin
                            r_state <= w_line_full ? c_st_fin : c_st_pad;
                        end
                    end
                end
                c_st_load_d: begin
                    if (w_in_acc) begin
                        dmem_we    <= 1'b1;
                        // Adding whole words never disturbs the low two bits,
                        // so masking after the add equals aligning the base.
                        dmem_addr  <= (r_base + (ADDR_LEN'(r_word_idx) << 2))
                                      & ~ADDR_LEN'(3);
                        dmem_wdata <= in_data;
                        r_word_idx <= r_word_idx + CNT_W'(1);
                        if (w_final) begin
                            r_state <= c_st_fin;
                        end
                    end
                end
                c_st_pad: begin
                    r_state <= c_st_fin;
                end
                c_st_fin: begin
                    done    <= 1'b1;
                    r_state <= c_st_idle;
                    if (r_last) begin
                        core_hold <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
